// File: rtl/dec_move.sv
// Plane position controller: turns synchronized move requests into clamped
// X/Y steps with press-and-hold auto-repeat.

`ifndef UP
`define UP    2'd0
`endif
`ifndef DOWN
`define DOWN  2'd1
`endif
`ifndef LEFT
`define LEFT  2'd2
`endif
`ifndef RIGHT
`define RIGHT 2'd3
`endif

module dec_move #(
  parameter int X_W           = 10,
  parameter int Y_W           = 10,
  parameter int X_MAX         = 620,
  parameter int Y_MAX         = 460,
  parameter int X_INIT        = 310,
  parameter int Y_INIT        = 400,
  parameter int STEP          = 4,
  parameter int REPEAT_DLY    = 6_000_000,
  parameter int REPEAT_PERIOD = 1_000_000,
  parameter int CNT_W         = 23
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           move_en_i,
  input  logic [1:0]     direct_i,
  output logic [X_W-1:0] pos_x_o,
  output logic [Y_W-1:0] pos_y_o,
  output logic           moving_o,
  output logic           step_o,
  output logic           blocked_o
);

  // IDLE   | no request held
  // DELAY  | stepped once, waiting for the first auto-repeat
  // REPEAT | auto-repeating at the repeat period
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  // Clamp thresholds held one bit wider than the coordinate so no sum wraps.
  localparam logic [X_W:0] X_STEP  = (X_W+1)'(STEP);
  localparam logic [X_W:0] X_LIM   = (X_W+1)'(X_MAX);
  localparam logic [X_W:0] X_RTHR  = (X_W+1)'(X_MAX - STEP);
  localparam logic [Y_W:0] Y_STEP  = (Y_W+1)'(STEP);
  localparam logic [Y_W:0] Y_LIM   = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W:0] Y_DTHR  = (Y_W+1)'(Y_MAX - STEP);

  logic [2:0]       sync_meta, sync_q;
  logic             men_s;
  logic [1:0]       dir_s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       cur_dir, dir_nxt;
  logic             step_ev;
  logic [X_W:0]     x_ext, x_nxt;
  logic [Y_W:0]     y_ext, y_nxt;

  // Two-flop synchronizer for the asynchronous button request and direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= {move_en_i, direct_i};
      sync_q    <= sync_meta;
    end
  end

  assign men_s    = sync_q[2];
  assign dir_s    = sync_q[1:0];
  assign moving_o = men_s;

  // FSM state, repeat counter and latched direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cur_dir <= `UP;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cur_dir <= dir_nxt;
    end
  end

  // Next-state logic; release wins over both expiry and direction change.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dir_nxt   = cur_dir;
    step_ev   = 1'b0;
    case (state)
      IDLE: begin
        if (men_s) begin
          step_ev   = 1'b1;
          dir_nxt   = dir_s;
          cnt_nxt   = '0;
          state_nxt = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (!men_s) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (dir_s != cur_dir) begin
          step_ev   = 1'b1;
          dir_nxt   = dir_s;
          cnt_nxt   = '0;
          state_nxt = DELAY;
        end else if (cnt == ((state == DELAY) ? DLY_LAST : PER_LAST)) begin
          step_ev   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = REPEAT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Clamped candidate position for a step in the synchronized direction.
  always_comb begin
    x_ext = {1'b0, pos_x_o};
    y_ext = {1'b0, pos_y_o};
    x_nxt = x_ext;
    y_nxt = y_ext;
    case (dir_s)
      `RIGHT:  x_nxt = (x_ext > X_RTHR) ? X_LIM : x_ext + X_STEP;
      `LEFT:   x_nxt = (x_ext < X_STEP) ? '0    : x_ext - X_STEP;
      `DOWN:   y_nxt = (y_ext > Y_DTHR) ? Y_LIM : y_ext + Y_STEP;
      default: y_nxt = (y_ext < Y_STEP) ? '0    : y_ext - Y_STEP;
    endcase
  end

  // Position registers and the step/blocked pulses that accompany each update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x_o   <= X_W'(X_INIT);
      pos_y_o   <= Y_W'(Y_INIT);
      step_o    <= 1'b0;
      blocked_o <= 1'b0;
    end else begin
      step_o    <= 1'b0;
      blocked_o <= 1'b0;
      if (step_ev) begin
        pos_x_o <= x_nxt[X_W-1:0];
        pos_y_o <= y_nxt[Y_W-1:0];
        if ((x_nxt != x_ext) || (y_nxt != y_ext)) step_o <= 1'b1;
        else                                      blocked_o <= 1'b1;
      end
    end
  end

endmodule
